// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, requester ids and counter width for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner selection between CPU and DMA requesters
// MEM_ARB_FIXED_PRIO_EN: CPU always wins a tie; otherwise round-robin on last_grant.
module mem_arb_pick (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic load,
  output logic winner
);
  import mem_arb_pkg::*;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst, load};
  assign winner   = (dma_req && !cpu_req) ? REQ_DMA : REQ_CPU;
`else
  logic r_last_grant;

  // Ids are one bit, so the requester that did not win last is the inverted grant.
  always_comb begin
    winner = REQ_CPU;
    if (cpu_req && dma_req) winner = ~r_last_grant;
    else if (dma_req)       winner = REQ_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_last_grant <= REQ_DMA;
    else if (load) r_last_grant <= winner;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter and sequencer for the shared memory port
// MEM_ARB_FIXED_PRIO_EN (in mem_arb_pick) selects fixed CPU priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import mem_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  logic             r_id;
  logic             r_we;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [DW-1:0]    r_mem_wdata;
  logic [DW-1:0]    r_cpu_rdata;
  logic [DW-1:0]    r_dma_rdata;
  logic             r_cpu_ack;
  logic             r_dma_ack;

  logic w_any;
  logic w_load;
  logic w_winner;

  assign w_any  = cpu_req | dma_req;
  assign w_load = (r_state == ST_IDLE) && w_any;

  mem_arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .load    (w_load),
    .winner  (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_id        <= REQ_CPU;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The memory strobe is registered, so it is raised on entry to ISSUE.
          if (w_any) begin
            r_id     <= w_winner;
            r_mem_en <= 1'b1;
            r_state  <= ST_ISSUE;
            if (w_winner == REQ_DMA) begin
              r_we        <= dma_we;
              r_mem_we    <= dma_we;
              r_mem_addr  <= dma_addr;
              r_mem_wdata <= dma_wdata;
            end else begin
              r_we        <= cpu_we;
              r_mem_we    <= cpu_we;
              r_mem_addr  <= cpu_addr;
              r_mem_wdata <= cpu_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (r_we) begin
            r_cpu_ack <= (r_id == REQ_CPU);
            r_dma_ack <= (r_id == REQ_DMA);
            r_state   <= ST_RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_id == REQ_DMA) r_dma_rdata <= mem_rdata;
            else                 r_cpu_rdata <= mem_rdata;
            r_cpu_ack <= (r_id == REQ_CPU);
            r_dma_ack <= (r_id == REQ_DMA);
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule
